// File: rtl/md_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_pkg
//  Description : Shared constants, types and the RV32M decode helper for the
//                mul/div issue stage.
//  Revision    : 1.0  initial release
// ============================================================================
package md_issue_pkg;

  // Register address width (x0..x127)
  localparam int ADDR_W = 7;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // mul/div unit function codes
  localparam logic [7:0] FN_IDLE = 8'h00;
  localparam logic [7:0] FN_MACL = 8'h1C;
  localparam logic [7:0] FN_MACH = 8'h1D;
  localparam logic [7:0] FN_DIVQ = 8'h1E;
  localparam logic [7:0] FN_DIVR = 8'h1F;

  // control2 = {mac_init, rs1_sign, rs2_sign}
  localparam int C2_MAC_INIT = 2;
  localparam int C2_RS1_SIGN = 1;
  localparam int C2_RS2_SIGN = 0;

  typedef struct packed {
    logic [7:0] fn;
    logic [2:0] control2;
    logic       is_div;
  } md_dec_t;

  // Map an RV32M funct3 onto the mul/div unit's fn / control2 pair.
  // is_div marks every op that occupies a divider result-FIFO slot.
  function automatic md_dec_t md_decode(input logic [2:0] funct3);
    md_dec_t d;
    d.fn       = FN_IDLE;
    d.control2 = 3'b000;
    d.is_div   = 1'b0;
    case (funct3)
      F3_MUL: begin
        d.fn = FN_MACL;
        d.control2[C2_MAC_INIT] = 1'b1;
      end
      F3_MULH: begin
        d.fn = FN_MACH;
        d.control2[C2_MAC_INIT] = 1'b1;
        d.control2[C2_RS1_SIGN] = 1'b1;
        d.control2[C2_RS2_SIGN] = 1'b1;
      end
      F3_MULHSU: begin
        d.fn = FN_MACH;
        d.control2[C2_MAC_INIT] = 1'b1;
        d.control2[C2_RS1_SIGN] = 1'b1;
      end
      F3_MULHU: begin
        d.fn = FN_MACH;
        d.control2[C2_MAC_INIT] = 1'b1;
      end
      F3_DIV: begin
        d.fn     = FN_DIVQ;
        d.is_div = 1'b1;
        d.control2[C2_RS1_SIGN] = 1'b1;
        d.control2[C2_RS2_SIGN] = 1'b1;
      end
      F3_DIVU: begin
        d.fn     = FN_DIVQ;
        d.is_div = 1'b1;
      end
      F3_REM: begin
        d.fn     = FN_DIVR;
        d.is_div = 1'b1;
        d.control2[C2_RS1_SIGN] = 1'b1;
        d.control2[C2_RS2_SIGN] = 1'b1;
      end
      F3_REMU: begin
        d.fn     = FN_DIVR;
        d.is_div = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : md_scoreboard
//  Description : Destination scoreboard for the mul/div unit. Tracks pending
//                destinations, which of them are divides, the number of
//                outstanding divides, and flags writebacks to idle registers.
//                Build option MD_WB_BYPASS_EN lets a same-cycle writeback
//                clear its address for the hazard lookup.
//  Revision    : 1.0  initial release
// ============================================================================
module md_scoreboard
  import md_issue_pkg::*;
#(
  parameter int NREG    = 128,
  parameter int MAX_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_add_i,
  input  logic [ADDR_W-1:0] rs2_add_i,
  input  logic [ADDR_W-1:0] rd_add_i,
  input  logic              set_i,
  input  logic              set_div_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_add_i,
  output logic              hazard_o,
  output logic              div_full_o,
  output logic              sb_err_o
);

  localparam logic [3:0] DIV_LIMIT = 4'(MAX_DIV);

  logic [NREG-1:0] pend_q,  pend_d;
  logic [NREG-1:0] isdiv_q, isdiv_d;
  logic [3:0]      div_cnt_q, div_cnt_d;
  logic            sb_err_q, sb_err_d;

  logic [NREG-1:0] wb_clear_mask;
  logic [NREG-1:0] pend_view;
  logic            div_inc;
  logic            div_dec;

`ifdef MD_WB_BYPASS_EN
  assign wb_clear_mask = wb_en_i ? ({{(NREG-1){1'b0}}, 1'b1} << wb_add_i) : '0;
`else
  assign wb_clear_mask = '0;
`endif

  // Bitmap seen by the hazard lookup (bypass removes the retiring address)
  assign pend_view = pend_q & ~wb_clear_mask;

  assign hazard_o = ((|rs1_add_i) & pend_view[rs1_add_i])
                  | ((|rs2_add_i) & pend_view[rs2_add_i])
                  | ((|rd_add_i)  & pend_view[rd_add_i]);

  assign div_full_o = (div_cnt_q == DIV_LIMIT);
  assign sb_err_o   = sb_err_q;

  // Counter is saturated at both ends so it cannot wrap on misuse
  assign div_inc = set_i & set_div_i & (div_cnt_q != DIV_LIMIT);
  assign div_dec = wb_en_i & isdiv_q[wb_add_i] & (div_cnt_q != 4'd0);

  // Next-state: writeback clears first, issue sets last so a same-cycle
  // set and clear of one address leaves it pending.
  always_comb begin
    pend_d    = pend_q;
    isdiv_d   = isdiv_q;
    div_cnt_d = div_cnt_q;
    sb_err_d  = sb_err_q;
    if (wb_en_i) begin
      pend_d[wb_add_i]  = 1'b0;
      isdiv_d[wb_add_i] = 1'b0;
      if (!pend_q[wb_add_i]) begin
        sb_err_d = 1'b1;
      end
    end
    if (set_i && (rd_add_i != '0)) begin
      pend_d[rd_add_i]  = 1'b1;
      isdiv_d[rd_add_i] = set_div_i;
    end
    case ({div_inc, div_dec})
      2'b10:   div_cnt_d = div_cnt_q + 4'd1;
      2'b01:   div_cnt_d = div_cnt_q - 4'd1;
      default: div_cnt_d = div_cnt_q;
    endcase
  end

  // Scoreboard state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      isdiv_q   <= '0;
      div_cnt_q <= 4'd0;
      sb_err_q  <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      isdiv_q   <= isdiv_d;
      div_cnt_q <= div_cnt_d;
      sb_err_q  <= sb_err_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/md_issue.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue
//  Description : Issue stage for the RV32M mul/div unit. Decodes funct3,
//                checks hazards against the destination scoreboard and
//                registers fn / control2 / operands / rd for the unit.
//                Build option MD_WB_BYPASS_EN forwards wb_data into the
//                operands and lets a dependent op issue in the writeback cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module md_issue
  import md_issue_pkg::*;
#(
  parameter int NREG    = 128,
  parameter int MAX_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        in_valid,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_rs1_add,
  input  logic [6:0]  in_rs2_add,
  input  logic [6:0]  in_rd_add,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic        md_pause_next,
  input  logic        wb_en,
  input  logic [6:0]  wb_add,
  input  logic [31:0] wb_data,
  output logic        issue_stall,
  output logic [7:0]  md_fn,
  output logic [2:0]  md_control2,
  output logic [31:0] md_rs1,
  output logic [31:0] md_rs2,
  output logic [6:0]  md_rd_add,
  output logic        sb_err
);

  md_dec_t     dec;
  logic        hazard;
  logic        div_full;
  logic        accept;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic [7:0]  md_fn_q,   md_fn_d;
  logic [2:0]  md_c2_q,   md_c2_d;
  logic [31:0] md_rs1_q,  md_rs1_d;
  logic [31:0] md_rs2_q,  md_rs2_d;
  logic [6:0]  md_rd_q,   md_rd_d;

  assign dec = md_decode(in_funct3);

  assign issue_stall = in_valid & (hazard | md_pause_next | (dec.is_div & div_full));
  assign accept      = in_valid & ~issue_stall & ~pause;

`ifdef MD_WB_BYPASS_EN
  assign rs1_val = (wb_en && (wb_add == in_rs1_add) && (in_rs1_add != '0)) ? wb_data : in_rs1;
  assign rs2_val = (wb_en && (wb_add == in_rs2_add) && (in_rs2_add != '0)) ? wb_data : in_rs2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign rs1_val = in_rs1;
  assign rs2_val = in_rs2;
`endif

  md_scoreboard #(
    .NREG    (NREG),
    .MAX_DIV (MAX_DIV)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .rs1_add_i  (in_rs1_add),
    .rs2_add_i  (in_rs2_add),
    .rd_add_i   (in_rd_add),
    .set_i      (accept),
    .set_div_i  (dec.is_div),
    .wb_en_i    (wb_en),
    .wb_add_i   (wb_add),
    .hazard_o   (hazard),
    .div_full_o (div_full),
    .sb_err_o   (sb_err)
  );

  // Output next-state: load on accept, hold while paused, else go idle
  always_comb begin
    md_fn_d  = md_fn_q;
    md_c2_d  = md_c2_q;
    md_rs1_d = md_rs1_q;
    md_rs2_d = md_rs2_q;
    md_rd_d  = md_rd_q;
    if (accept) begin
      md_fn_d  = dec.fn;
      md_c2_d  = dec.control2;
      md_rs1_d = rs1_val;
      md_rs2_d = rs2_val;
      md_rd_d  = in_rd_add;
    end else if (!pause) begin
      md_fn_d  = FN_IDLE;
      md_c2_d  = 3'b000;
    end
  end

  // Output registers toward the mul/div unit
  always_ff @(posedge clk) begin
    if (reset) begin
      md_fn_q  <= FN_IDLE;
      md_c2_q  <= 3'b000;
      md_rs1_q <= 32'd0;
      md_rs2_q <= 32'd0;
      md_rd_q  <= 7'd0;
    end else begin
      md_fn_q  <= md_fn_d;
      md_c2_q  <= md_c2_d;
      md_rs1_q <= md_rs1_d;
      md_rs2_q <= md_rs2_d;
      md_rd_q  <= md_rd_d;
    end
  end

  assign md_fn       = md_fn_q;
  assign md_control2 = md_c2_q;
  assign md_rs1      = md_rs1_q;
  assign md_rs2      = md_rs2_q;
  assign md_rd_add   = md_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_md_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_issue
//  Description : Directed self-checking bench for md_issue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [6:0]  in_rs1_add, in_rs2_add, in_rd_add;
  logic [31:0] in_rs1, in_rs2;
  logic        md_pause_next;
  logic        wb_en;
  logic [6:0]  wb_add;
  logic [31:0] wb_data;
  logic        issue_stall;
  logic [7:0]  md_fn;
  logic [2:0]  md_control2;
  logic [31:0] md_rs1, md_rs2;
  logic [6:0]  md_rd_add;
  logic        sb_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  md_issue dut (
    .clk           (clk),
    .reset         (reset),
    .pause         (pause),
    .in_valid      (in_valid),
    .in_funct3     (in_funct3),
    .in_rs1_add    (in_rs1_add),
    .in_rs2_add    (in_rs2_add),
    .in_rd_add     (in_rd_add),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .md_pause_next (md_pause_next),
    .wb_en         (wb_en),
    .wb_add        (wb_add),
    .wb_data       (wb_data),
    .issue_stall   (issue_stall),
    .md_fn         (md_fn),
    .md_control2   (md_control2),
    .md_rs1        (md_rs1),
    .md_rs2        (md_rs2),
    .md_rd_add     (md_rd_add),
    .sb_err        (sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock, land 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // present an op to the issue stage and let combinational logic settle
  task automatic op(input logic [2:0] f3, input logic [6:0] a1, input logic [6:0] a2,
                    input logic [6:0] d, input logic [31:0] v1, input logic [31:0] v2);
    in_valid   = 1'b1;
    in_funct3  = f3;
    in_rs1_add = a1;
    in_rs2_add = a2;
    in_rd_add  = d;
    in_rs1     = v1;
    in_rs2     = v2;
    #1;
  endtask

  task automatic wb(input logic [6:0] a);
    wb_en  = 1'b1;
    wb_add = a;
    cyc();
    wb_en  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; in_valid = 1'b0; in_funct3 = 3'd0;
    in_rs1_add = '0; in_rs2_add = '0; in_rd_add = '0; in_rs1 = '0; in_rs2 = '0;
    md_pause_next = 1'b0; wb_en = 1'b0; wb_add = '0; wb_data = '0;
    cyc(); cyc();
    reset = 1'b0;

    // reset state
    chk("rst_fn", md_fn, 0);
    chk("rst_c2", md_control2, 0);
    chk("rst_rs1", md_rs1, 0);
    chk("rst_rs2", md_rs2, 0);
    chk("rst_rd", md_rd_add, 0);
    chk("rst_sberr", sb_err, 0);
    chk("rst_stall", issue_stall, 0);

    // MULHSU issue
    op(3'd2, 7'd10, 7'd11, 7'd5, 32'hFFFF_FFFF, 32'd2);
    chk("mulhsu_stall", issue_stall, 0);
    cyc();
    in_valid = 1'b0;
    chk("mulhsu_fn", md_fn, 32'h1D);
    chk("mulhsu_c2", md_control2, 3'b110);
    chk("mulhsu_rd", md_rd_add, 5);
    chk("mulhsu_rs1", md_rs1, 32'hFFFF_FFFF);
    chk("mulhsu_rs2", md_rs2, 2);
    op(3'd0, 7'd5, 7'd0, 7'd20, 32'd0, 32'd0);
    chk("raw_pend5", issue_stall, 1);
    op(3'd0, 7'd0, 7'd0, 7'd5, 32'd0, 32'd0);
    chk("waw_pend5", issue_stall, 1);
    in_valid = 1'b0;
    cyc();
    chk("fn_idle_after", md_fn, 0);
    wb(7'd5);
    chk("wb5_sberr", sb_err, 0);

    // DIV then dependent MUL
    op(3'd4, 7'd1, 7'd2, 7'd3, 32'd100, 32'd7);
    cyc();
    chk("div_fn", md_fn, 32'h1E);
    chk("div_c2", md_control2, 3'b011);
    chk("div_rd", md_rd_add, 3);
    op(3'd0, 7'd3, 7'd4, 7'd6, 32'h0000_DEAD, 32'd9);
    chk("dep_stall0", issue_stall, 1);
    cyc();
    chk("dep_stall1", issue_stall, 1);
    wb_en = 1'b1; wb_add = 7'd3; wb_data = 32'h1234_5678;
    #1;
`ifdef MD_WB_BYPASS_EN
    chk("dep_stall_w", issue_stall, 0);
    cyc();
    wb_en = 1'b0; in_valid = 1'b0;
`else
    chk("dep_stall_w", issue_stall, 1);
    cyc();
    wb_en = 1'b0; in_rs1 = 32'h1234_5678;
    #1;
    chk("dep_stall_w1", issue_stall, 0);
    cyc();
    in_valid = 1'b0;
`endif
    chk("dep_fn", md_fn, 32'h1C);
    chk("dep_c2", md_control2, 3'b100);
    chk("dep_rs1", md_rs1, 32'h1234_5678);
    chk("dep_rs2", md_rs2, 9);
    chk("dep_rd", md_rd_add, 6);
    wb(7'd6);

    // fill the divider queue
    for (int i = 1; i <= 8; i++) begin
      op(3'd4, 7'd0, 7'd0, 7'(i), 32'd0, 32'd0);
      chk("div_fill", issue_stall, 0);
      cyc();
    end
    op(3'd4, 7'd0, 7'd0, 7'd10, 32'd0, 32'd0);
    chk("div_full", issue_stall, 1);
    op(3'd0, 7'd0, 7'd0, 7'd9, 32'd0, 32'd0);
    chk("mul_when_full", issue_stall, 0);
    cyc();
    chk("mul_when_full_fn", md_fn, 32'h1C);
    op(3'd4, 7'd0, 7'd0, 7'd10, 32'd0, 32'd0);
    chk("div_full2", issue_stall, 1);
    wb_en = 1'b1; wb_add = 7'd1;
    #1;
    chk("div_full_wbcyc", issue_stall, 1);
    cyc();
    wb_en = 1'b0;
    #1;
    chk("div_slot_free", issue_stall, 0);
    cyc();
    in_valid = 1'b0;
    chk("div9_fn", md_fn, 32'h1E);
    chk("div9_rd", md_rd_add, 10);
    for (int i = 2; i <= 10; i++) wb(7'(i));
    chk("drain_sberr", sb_err, 0);

    // back-pressure and pause
    md_pause_next = 1'b1;
    op(3'd3, 7'd0, 7'd0, 7'd7, 32'd5, 32'd6);
    chk("mdpause_stall", issue_stall, 1);
    cyc();
    md_pause_next = 1'b0;
    chk("mdpause_no_out", md_fn, 0);
    #1;
    chk("mdpause_release", issue_stall, 0);
    cyc();
    in_valid = 1'b0; pause = 1'b1;
    chk("mulhu_fn", md_fn, 32'h1D);
    chk("mulhu_c2", md_control2, 3'b100);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("pause_hold", md_fn, 32'h1D);
    end
    pause = 1'b0;
    cyc();
    chk("pause_drop", md_fn, 0);
    pause = 1'b1;
    op(3'd0, 7'd0, 7'd0, 7'd0, 32'd1, 32'd1);
    cyc();
    chk("pause_blocks", md_fn, 0);
    in_valid = 1'b0; pause = 1'b0;
    wb(7'd7);

    // rd = x0 and back-to-back issue
    op(3'd0, 7'd0, 7'd0, 7'd0, 32'd11, 32'd22);
    chk("x0_stall", issue_stall, 0);
    cyc();
    op(3'd7, 7'd0, 7'd0, 7'd13, 32'd33, 32'd44);
    chk("b2b_stall", issue_stall, 0);
    chk("x0_fn", md_fn, 32'h1C);
    chk("x0_rd", md_rd_add, 0);
    chk("x0_rs1", md_rs1, 11);
    cyc();
    in_valid = 1'b0;
    chk("remu_fn", md_fn, 32'h1F);
    chk("remu_c2", md_control2, 0);
    chk("remu_rd", md_rd_add, 13);
    chk("remu_rs2", md_rs2, 44);
    wb(7'd13);
    chk("x0_sberr", sb_err, 0);

    // sb_err, reset mid-operation
    op(3'd4, 7'd0, 7'd0, 7'd14, 32'd0, 32'd0);
    cyc();
    in_valid = 1'b0;
    wb(7'd12);
    chk("sberr_set", sb_err, 1);
    cyc();
    chk("sberr_sticky", sb_err, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst2_sberr", sb_err, 0);
    chk("rst2_fn", md_fn, 0);
    op(3'd0, 7'd14, 7'd0, 7'd20, 32'd0, 32'd0);
    chk("rst2_pend", issue_stall, 0);
    for (int i = 1; i <= 8; i++) begin
      op(3'd4, 7'd0, 7'd0, 7'(i), 32'd0, 32'd0);
      chk("rst2_divcnt", issue_stall, 0);
      cyc();
    end
    op(3'd4, 7'd0, 7'd0, 7'd9, 32'd0, 32'd0);
    chk("rst2_full", issue_stall, 1);
    in_valid = 1'b0;
    wb(7'd14);
    chk("late_wb_sberr", sb_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
